cmp_sel_shift_pipe: RTL
=======================

Name: cmp_sel_shift_pipe

Overview:
- Parametrised, pipelined compare/select/shift datapath. Per operand triple it computes d=a+b, e=a+c, f=a-b, selects by compare, shifts by the compare flags, and narrows to the output width.
- Adds a valid/ready handshake with backpressure, a selectable narrowing mode (truncate or saturate) and an overflow flag.
- Sits between an operand producer and a result consumer in the component-module datapath library.

Parameters:
- DATAWIDTH, 64, width of a, b, c and of all internal arithmetic.
- OUTWIDTH, 32, width of x and z; legal range 1..DATAWIDTH.
- SATURATE, 0, narrowing mode: 0 = keep low OUTWIDTH bits; 1 = clamp to all-ones when any discarded upper bit is 1.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous reset, active-high.
- a  input  DATAWIDTH  operand, unsigned.
- b  input  DATAWIDTH  operand, unsigned.
- c  input  DATAWIDTH  operand, unsigned.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  block can accept the triple this cycle.
- x  output  OUTWIDTH  narrowed (h << dLTe).
- z  output  OUTWIDTH  narrowed (g >> dEQe).
- ovf  output  1  x or z lost nonzero upper bits during narrowing.
- out_valid  output  1  x, z, ovf valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- One clock domain: Clk. Reset is asynchronous and active-high (Rst).
- Reset: all stage valid bits, out_valid, x, z and ovf clear to 0 immediately on Rst. Rst asserted mid-operation discards all in-flight data.
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall, combinational. While stalled, every stage register, including its valid bit, holds.
- Bubbles are not squeezed out; the pipeline is a rigid 3-stage shift.
- Stage 1 (registered on accept):
  - d = a+b and e = a+c, each mod 2^DATAWIDTH.
  - f = a-b, mod 2^DATAWIDTH, wrapping.
  - dLTe = (d < e), unsigned. dEQe = (d == e).
  - Stage-1 valid = in_valid && in_ready when not stalled.
- Stage 2:
  - g = dLTe ? d : e.
  - h = dEQe ? g : f.
  - Register g, h, dLTe, dEQe and valid.
- Stage 3 (output register):
  - xw = h << dLTe, a DATAWIDTH-bit result; the MSB shifted out is dropped.
  - zw = g >> dEQe, logical shift.
  - Narrowing per SATURATE, applied independently to x and z.
  - ovf = (xw[DATAWIDTH-1:OUTWIDTH] != 0) || (zw[DATAWIDTH-1:OUTWIDTH] != 0).
  - When OUTWIDTH == DATAWIDTH, ovf is constant 0.
  - out_valid = stage-2 valid.
- Latency: 3 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 result per cycle.
- Holding: x, z and ovf stay stable while out_valid && !out_ready.
- When out_valid = 0, x, z and ovf hold their last values and carry no meaning.
- Simultaneous out_ready rising and in_valid in the same cycle: the pipeline advances and accepts the new input that cycle.
- Ordering: results emerge in input order; nothing is dropped or duplicated under any in_valid/out_ready pattern.

Test Plan:
- Default parameters, out_ready=1. Input a=10, b=3, c=5 (d=13, e=15, f=7, dLTe=1) -> 3 cycles later out_valid=1, x=14, z=13, ovf=0.
- Equal branch. Input a=4, b=2, c=2 (d=e=6, dEQe=1, g=h=6) -> x=6, z=3, ovf=0.
- Subtract wrap. Input a=1, b=2, c=0 (f=2^64-1, g=1) -> x=0xFFFFFFFF, z=1, ovf=1, for both SATURATE=0 and SATURATE=1.
- Saturation. Input a=0x1_0000_0000, b=0, c=1 (g=h=0x1_0000_0000, dLTe=1):
  - SATURATE=0 -> x=0, z=0, ovf=1.
  - SATURATE=1 -> x=0xFFFFFFFF, z=0xFFFFFFFF, ovf=1.
- Backpressure. Stream 6 triples back-to-back with out_ready low for 4 cycles mid-stream -> in_ready drops in the same cycle as stall; held outputs are stable; all 6 results arrive in order with no loss or duplication.
- Reset. Assert Rst asynchronously (off a Clk edge) with 3 triples in flight -> out_valid, x, z and ovf are 0 before the next Clk edge. After release, the next input produces its result exactly 3 cycles later.

Source files
------------

// File: rtl/cmp_sel_shift_pipe.sv
// Three-stage compare/select/shift datapath: sums and difference, min-style select,
// flag-driven shifts, then narrowing to OUTWIDTH with optional saturation and overflow flag.
module cmp_sel_shift_pipe #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUTWIDTH-1:0]  x,
    output logic [OUTWIDTH-1:0]  z,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Handshake: a beat moves on any edge where valid && ready. The only stall source is an
    // unaccepted result (out_valid && !out_ready); it freezes all three stages and drops
    // in_ready in the same cycle, so a producer never loses a beat.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    logic [DATAWIDTH-1:0] sum_d, sum_e, dif_f;
    logic                 lt_n, eq_n;
    assign sum_d = a + b;
    assign sum_e = a + c;
    assign dif_f = a - b;
    assign lt_n  = sum_d < sum_e;
    assign eq_n  = sum_d == sum_e;

    logic [DATAWIDTH-1:0] d1, e1, f1;
    logic                 lt1, eq1, v1;

    logic [DATAWIDTH-1:0] g_n, h_n;
    assign g_n = lt1 ? d1 : e1;
    assign h_n = eq1 ? g_n : f1;

    logic [DATAWIDTH-1:0] g2, h2;
    logic                 lt2, eq2, v2;

    logic [DATAWIDTH-1:0] xw, zw;
    assign xw = h2 << lt2;
    assign zw = g2 >> eq2;

    // Upper-bit detection only exists when narrowing actually discards bits.
    logic x_hi, z_hi;
    generate
        if (OUTWIDTH < DATAWIDTH) begin : g_narrow
            assign x_hi = |xw[DATAWIDTH-1:OUTWIDTH];
            assign z_hi = |zw[DATAWIDTH-1:OUTWIDTH];
        end else begin : g_full
            assign x_hi = 1'b0;
            assign z_hi = 1'b0;
        end
    endgenerate

    logic [OUTWIDTH-1:0] x_n, z_n;
    assign x_n = ((SATURATE != 0) && x_hi) ? {OUTWIDTH{1'b1}} : xw[OUTWIDTH-1:0];
    assign z_n = ((SATURATE != 0) && z_hi) ? {OUTWIDTH{1'b1}} : zw[OUTWIDTH-1:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            d1        <= '0;
            e1        <= '0;
            f1        <= '0;
            lt1       <= 1'b0;
            eq1       <= 1'b0;
            v1        <= 1'b0;
            g2        <= '0;
            h2        <= '0;
            lt2       <= 1'b0;
            eq2       <= 1'b0;
            v2        <= 1'b0;
            x         <= '0;
            z         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1  <= sum_d;
                e1  <= sum_e;
                f1  <= dif_f;
                lt1 <= lt_n;
                eq1 <= eq_n;
            end
            v2 <= v1;
            if (v1) begin
                g2  <= g_n;
                h2  <= h_n;
                lt2 <= lt1;
                eq2 <= eq1;
            end
            out_valid <= v2;
            // Outputs keep their last values across bubbles.
            if (v2) begin
                x   <= x_n;
                z   <= z_n;
                ovf <= x_hi || z_hi;
            end
        end
    end

endmodule
